clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised multi-channel clock-enable/divided-clock generator driven from the 50 MHz board clock. Each of CH channels has a runtime-programmable half-period divisor, an individual enable and a glitch-free divisor update. A global sync restarts all channels phase-aligned. It replaces fixed per-frequency divider blocks (1 Hz/10 Hz/100 Hz/1 kHz) for display scan, debounce and timekeeping logic.

## Interface
- CH, 4, number of channels (1..16)
- CW, 32, divisor/counter width
- DEF_DIV, {CH{32'd25_000}}, packed CH×CW reset divisors, channel 0 in LSBs
- clk_50MHz  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  CH  per-channel run enable
- sync  in  1  one-cycle pulse; restarts all channels together
- wr_en  in  1  divisor write strobe
- wr_ch  in  $clog2(CH) (min 1)  channel to write
- wr_div  in  CW  new half-period divisor
- clk_out  out  CH  divided square waves
- tick  out  CH  one-cycle strobe per full output period

## Operation
- Per channel: shadow divisor `shd`, active divisor `act`, counter `cnt`, output `out`.
- Reset (rst=0): shd=act=DEF_DIV slice, cnt=0, clk_out=0, tick=0.
- Write: wr_en=1 loads wr_div into shd of channel wr_ch; wr_ch≥CH ignored.
- act <= shd when: cnt reaches terminal (cnt==act-1), channel disabled (en=0), act==0, or sync=1. Mid-period writes never shorten/lengthen the current half-period.
- Running (en=1, act≠0): cnt==act-1 → cnt<=0, out<=~out; else cnt<=cnt+1.
- en=0: cnt<=0, out<=0 (stop low). act==0: same as disabled (out held 0).
- Output frequency = 50 MHz / (2·act); act=1 → 25 MHz; act=25_000_000 → 1 Hz.
- sync=1: all channels cnt<=0, out<=0, act<=shd (after same-cycle write, i.e. write in sync cycle takes effect). sync overrides counting and terminal toggle.
- Priority per cycle: rst > sync > en=0 > act==0 > count.
- tick[i]=1 for exactly one cycle in the cycle clk_out[i] becomes 1 (registered, coincident with rising edge of out).

## Timing
- clk_out and tick are registered; no combinational path from inputs to outputs.
- en sampled high at edge 0 (cnt=0): first rise of clk_out after edge act-1 count completes, i.e. clk_out=1 visible after act edges; fall after 2·act edges; period 2·act cycles, duty exactly 50%.
- Write latency: shd updated 1 edge after wr_en; takes effect at next terminal count, so new period starts on next toggle.
- sync: all clk_out=0 the cycle after; all channels with equal act rise simultaneously act edges later.
- Counter never exceeds act-1; no wrap at CW overflow because terminal always hit first.

## Configuration
- CLK_DIV_TICK_EN defined: tick logic compiled in as above.
- Not defined: tick port present but driven constant 0; no tick registers synthesised.

## Structure
- Package clk_div_pkg: CW default, divisor constants for 50 MHz source (DIV_1HZ=25_000_000, DIV_10HZ=2_500_000, DIV_100HZ=250_000, DIV_1KHZ=25_000), channel-index width function.
- Sub-module clk_div_ch: one channel (shd/act/cnt/out/tick), instantiated CH times via generate; top holds write decode and sync fan-out.

## Test plan
- Reset: rst=0 mid-run → clk_out=0, tick=0 immediately (async); after release with en=1, DEF_DIV=4 → rise at edge 4, period 8 cycles.
- Divisor write mid-period: act=4, write 2 when cnt=1 → current half-period stays 4, subsequent half-periods 2 cycles.
- act=1 and act=0: act=1 → clk_out toggles every cycle; write 0 → clk_out held 0, tick never asserts.
- sync alignment: ch0 act=3, ch1 act=3 out of phase, pulse sync → both 0 next cycle, both rise together 3 edges later.
- en drop: en[2]=0 while clk_out[2]=1 → clk_out[2]=0 next cycle, cnt cleared; re-enable → full first half-period.
- tick (CLK_DIV_TICK_EN): act=5 → tick one cycle every 10 cycles aligned with clk_out rise; without macro tick stays 0; wr_ch=CH (invalid) → no channel changes.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared width default, 50 MHz divisor constants and channel-index width helper.
// Used by clk_div_bank (optional tick logic controlled by CLK_DIV_TICK_EN).
package clk_div_pkg;
    localparam int CW_DEF = 32;
    localparam logic [31:0] DIV_1HZ   = 32'd25_000_000;
    localparam logic [31:0] DIV_10HZ  = 32'd2_500_000;
    localparam logic [31:0] DIV_100HZ = 32'd250_000;
    localparam logic [31:0] DIV_1KHZ  = 32'd25_000;

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadow/active divisor, 50% duty output and rise strobe.
// CLK_DIV_TICK_EN compiles in the tick register; otherwise tick is tied low.
module clk_div_ch #(
    parameter int CW = 32,
    parameter logic [CW-1:0] DEF = '0
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          clk_out,
    output logic          tick
);
    localparam logic [CW-1:0] ONE = 1;

    logic [CW-1:0] shd, act, cnt;
    logic run, term, load;

    always_comb begin
        run  = en && act != '0;
        term = run && cnt == act - ONE;
        load = sync || !run || term;
    end

    // A divisor written in the sync cycle bypasses the shadow so sync restarts on it.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            shd     <= DEF;
            act     <= DEF;
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            if (wr) shd <= wr_div;
            if (load) act <= (sync && wr) ? wr_div : shd;
            cnt     <= (sync || !run || term) ? '0 : cnt + ONE;
            clk_out <= (sync || !run) ? 1'b0 : (term ? ~clk_out : clk_out);
        end
    end

`ifdef CLK_DIV_TICK_EN
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) tick <= 1'b0;
        else      tick <= !sync && term && !clk_out;
    end
`else
    assign tick = 1'b0;
`endif
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH programmable clock dividers with write decode and shared phase-aligning sync.
// Define CLK_DIV_TICK_EN to build the per-channel tick strobes.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = CW_DEF,
    parameter logic [CH*CW-1:0] DEF_DIV = {CH{DIV_1KHZ}}
) (
    input  logic                      clk_50MHz,
    input  logic                      rst,
    input  logic [CH-1:0]             en,
    input  logic                      sync,
    input  logic                      wr_en,
    input  logic [ch_idx_w(CH)-1:0]   wr_ch,
    input  logic [CW-1:0]             wr_div,
    output logic [CH-1:0]             clk_out,
    output logic [CH-1:0]             tick
);
    localparam int WW = ch_idx_w(CH);

    // Out-of-range wr_ch values match no channel, so such writes are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_div_ch #(.CW(CW), .DEF(DEF_DIV[i*CW +: CW])) u_ch (
            .clk_50MHz (clk_50MHz),
            .rst       (rst),
            .en        (en[i]),
            .sync      (sync),
            .wr        (wr_en && wr_ch == WW'(i)),
            .wr_div    (wr_div),
            .clk_out   (clk_out[i]),
            .tick      (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed scenarios plus random traffic against a per-channel phase model.
module tb_clk_div_bank;
    localparam int CH = 5;
    localparam int CW = 32;
    localparam logic [CH*CW-1:0] DEF = {CH{32'd4}};

    logic clk_50MHz = 1'b0;
    logic rst = 1'b0, sync = 1'b0, wr_en = 1'b0;
    logic [CH-1:0] en = '0, clk_out, tick;
    logic [2:0] wr_ch = '0;
    logic [CW-1:0] wr_div = '0;

    int checks = 0, failures = 0;
    longint m_shd[CH], m_act[CH], m_cnt[CH];
    bit m_out[CH], m_tick[CH];

    clk_div_bank #(.CH(CH), .CW(CW), .DEF_DIV(DEF)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_out();
        logic [31:0] v = '0;
        for (int i = 0; i < CH; i++) v[i] = m_out[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_tick();
        logic [31:0] v = '0;
`ifdef CLK_DIV_TICK_EN
        for (int i = 0; i < CH; i++) v[i] = m_tick[i];
`endif
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin
            m_shd[i] = 4; m_act[i] = 4; m_cnt[i] = 0; m_out[i] = 0; m_tick[i] = 0;
        end
    endtask

    // Model: each channel spends act cycles per half-period; the divisor in use is
    // re-read from the shadow at every half-period boundary, when idle, or on sync.
    task automatic step();
        if (!rst) m_reset();
        else for (int i = 0; i < CH; i++) begin
            longint nsh;
            bit go;
            nsh = (wr_en && wr_ch == i) ? longint'(wr_div) : m_shd[i];
            go = en[i] && m_act[i] != 0;
            m_tick[i] = 0;
            if (sync) begin
                m_cnt[i] = 0; m_out[i] = 0; m_act[i] = nsh;
            end else if (!go) begin
                m_cnt[i] = 0; m_out[i] = 0; m_act[i] = m_shd[i];
            end else if (m_cnt[i] == m_act[i] - 1) begin
                m_cnt[i] = 0; m_out[i] = !m_out[i]; m_tick[i] = m_out[i]; m_act[i] = m_shd[i];
            end else m_cnt[i]++;
            m_shd[i] = nsh;
        end
        @(posedge clk_50MHz);
        #1;
        check("clk_out", 32'(clk_out), exp_out());
        check("tick", 32'(tick), exp_tick());
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 3'(ch); wr_div = CW'(d);
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        m_reset();
        #1 check("reset_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        run(2);
        rst = 1'b1; en = '1;
        run(20);
        #3 rst = 1'b0;
        #1 check("async_rst_out", 32'(clk_out), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        m_reset();
        step();
        rst = 1'b1;
        run(1);
        write(0, 2);
        run(20);
        write(1, 1);
        run(12);
        write(2, 0);
        run(12);
        write(3, 3);
        en[4] = 1'b0; step(); en[4] = 1'b1;
        write(4, 3);
        run(4);
        sync = 1'b1; step(); sync = 1'b0;
        run(10);
        write(2, 4);
        run(3);
        for (int k = 0; k < 20 && !clk_out[2]; k++) step();
        check("en_drop_pre", 32'(clk_out[2]), 32'd1);
        en[2] = 1'b0; step(); en[2] = 1'b1;
        run(12);
        write(0, 5);
        run(25);
        write(5, 9);
        write(7, 1);
        run(10);
        repeat (3000) begin
            for (int i = 0; i < CH; i++) en[i] = $urandom_range(0, 9) != 0;
            wr_en = $urandom_range(0, 3) == 0;
            wr_ch = 3'($urandom_range(0, 7));
            wr_div = CW'($urandom_range(0, 6));
            sync = $urandom_range(0, 49) == 0;
            step();
        end
        wr_en = 1'b0; sync = 1'b0; en = '1;
        run(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
